// File: rtl/vga_mem.sv
// VGA timing generator with a frame-buffer read pipeline. Counters, address
// register, synchronous memory and output register give a 3-clock latency.
module vga_mem #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] mem_data,
    output logic [18:0] mem_addr,
    output logic        hs,
    output logic        vs,
    output logic [11:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ONE    = VW'(1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [18:0]   A_ONE    = 19'd1;
    localparam logic [18:0]   ADDR_MAX = 19'(H_ACTIVE * V_ACTIVE - 1);

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] w);
        return {w[15:12], w[10:7], w[4:1]};
    endfunction

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [18:0]   addr_cnt_q, addr_cnt_d;
    logic [18:0]   mem_addr_q, mem_addr_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
    logic          hs2_q, hs2_d, vs2_q, vs2_d, act2_q, act2_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          act_s, hsync_raw_s, vsync_raw_s;

    // Raster position decode for the pixel currently held in the counters.
    always_comb begin
        act_s       = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_raw_s = !((h_q >= HS_START) && (h_q <= HS_END));
        vsync_raw_s = !((v_q >= VS_START) && (v_q <= VS_END));
    end

    // Next-state for counters, address and the delay pipeline.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + V_ONE;
            end
        end else begin
            h_d = h_q + H_ONE;
            v_d = v_q;
        end

        // addr_cnt tracks the address of the counters' pixel; wrapping on the
        // last active pixel keeps it bounded and restarts each frame at 0.
        addr_cnt_d = addr_cnt_q;
        mem_addr_d = mem_addr_q;
        if (act_s) begin
            mem_addr_d = addr_cnt_q;
            if (addr_cnt_q == ADDR_MAX) begin
                addr_cnt_d = 19'd0;
            end else begin
                addr_cnt_d = addr_cnt_q + A_ONE;
            end
        end else begin
            addr_cnt_d = addr_cnt_q;
            mem_addr_d = mem_addr_q;
        end

        hs1_d  = hsync_raw_s;
        vs1_d  = vsync_raw_s;
        act1_d = act_s;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        act2_d = act1_q;
        hs_d   = hs2_q;
        vs_d   = vs2_q;
        if (act2_q) begin
            rgb_d = rgb565_to_444(mem_data);
        end else begin
            rgb_d = 12'h000;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            h_q        <= '0;
            v_q        <= '0;
            addr_cnt_q <= 19'd0;
            mem_addr_q <= 19'd0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            act1_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            act2_q     <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            rgb_q      <= 12'h000;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            addr_cnt_q <= addr_cnt_d;
            mem_addr_q <= mem_addr_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            act1_q     <= act1_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            act2_q     <= act2_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign hs       = hs_q;
    assign vs       = vs_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_vga_mem.sv
// Bench for vga_mem using a reduced raster so several frames fit in a short run.
module tb_vga_mem;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
    localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int ADDR_MAX = HA * VA - 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] mem_data;
    logic [18:0] mem_addr;
    logic        hs, vs;
    logic [11:0] rgb;

    vga_mem #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk(clk), .rstn(rstn), .mem_data(mem_data),
        .mem_addr(mem_addr), .hs(hs), .vs(vs), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int mode;
    logic [15:0] rnd_mem [0:127];

    function automatic logic [15:0] word_of(input logic [18:0] a);
        case (mode)
            0:       return a[15:0];
            1:       return 16'hFFFF;
            default: return rnd_mem[a[6:0]];
        endcase
    endfunction

    // One-clock synchronous frame buffer.
    always @(posedge clk) mem_data <= word_of(mem_addr);

    function automatic logic [11:0] to444(input logic [15:0] w);
        return {w[15:12], w[10:7], w[4:1]};
    endfunction

    int checks = 0, failures = 0;
    int k = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    int hs_fall = -1, vs_fall = -1, first_hs_fall = -1;
    int run_len = 0, lines_ffff = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    // Expected outputs from raster arithmetic: address lags the raster by 1, outputs by 3.
    task automatic model_check();
        logic exp_hs, exp_vs;
        logic [11:0] exp_rgb;
        int exp_addr, n, x, y;
        exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000; exp_addr = 0;
        if (k >= 1) begin
            n = (k - 1) % FRAME; x = n % HT; y = n / HT;
            if (y < VA) exp_addr = y * HA + ((x < HA) ? x : HA - 1);
            else        exp_addr = ADDR_MAX;
        end
        if (k >= 3) begin
            n = (k - 3) % FRAME; x = n % HT; y = n / HT;
            exp_hs = !(x >= HA + HFP && x < HA + HFP + HSW);
            exp_vs = !(y >= VA + VFP && y < VA + VFP + VSW);
            if (x < HA && y < VA) exp_rgb = to444(word_of(19'(y * HA + x)));
        end
        check("model_hs", 32'(hs), 32'(exp_hs));
        check("model_vs", 32'(vs), 32'(exp_vs));
        check("model_rgb", 32'(rgb), 32'(exp_rgb));
        check("model_addr", 32'(mem_addr), 32'(exp_addr));
    endtask

    task automatic step();
        logic rst_s;
        rst_s = rstn;
        @(posedge clk);
        #1;
        if (rst_s) k = 0;
        else       k++;
        model_check();
        if (rst_s) begin
            hs_fall = -1; vs_fall = -1; first_hs_fall = -1; run_len = 0;
        end else begin
            if (prev_hs && !hs) begin
                if (hs_fall >= 0) check("hs_period", 32'(k - hs_fall), 32'(HT));
                if (first_hs_fall < 0) first_hs_fall = k;
                hs_fall = k;
            end
            if (!prev_hs && hs && hs_fall >= 0) check("hs_low", 32'(k - hs_fall), 32'(HSW));
            if (prev_vs && !vs) begin
                if (vs_fall >= 0) check("vs_period", 32'(k - vs_fall), 32'(FRAME));
                vs_fall = k;
            end
            if (!prev_vs && vs && vs_fall >= 0) check("vs_low", 32'(k - vs_fall), 32'(VSW * HT));
            if (mode == 1) begin
                if (rgb == 12'hFFF) run_len++;
                else if (run_len > 0) begin
                    check("ffff_run", 32'(run_len), 32'(HA));
                    run_len = 0;
                    lines_ffff++;
                end
            end
        end
        prev_hs = hs;
        prev_vs = vs;
    endtask

    typedef struct {
        int          k;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic [18:0] addr;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{0,   1'b1, 1'b1, 12'h000, 19'd0};
        tbl[1]  = '{1,   1'b1, 1'b1, 12'h000, 19'd0};
        tbl[2]  = '{3,   1'b1, 1'b1, 12'h000, 19'd2};
        tbl[3]  = '{5,   1'b1, 1'b1, 12'h001, 19'd4};
        tbl[4]  = '{14,  1'b1, 1'b1, 12'h005, 19'd13};
        tbl[5]  = '{18,  1'b1, 1'b1, 12'h007, 19'd15};
        tbl[6]  = '{19,  1'b1, 1'b1, 12'h000, 19'd15};
        tbl[7]  = '{23,  1'b0, 1'b1, 12'h000, 19'd15};
        tbl[8]  = '{28,  1'b0, 1'b1, 12'h000, 19'd15};
        tbl[9]  = '{29,  1'b1, 1'b1, 12'h000, 19'd15};
        tbl[10] = '{33,  1'b1, 1'b1, 12'h008, 19'd18};
        tbl[11] = '{218, 1'b1, 1'b1, 12'h00A, 19'd119};
        tbl[12] = '{228, 1'b1, 1'b1, 12'h00F, 19'd127};
        tbl[13] = '{243, 1'b1, 1'b1, 12'h000, 19'd127};
        tbl[14] = '{303, 1'b1, 1'b0, 12'h000, 19'd127};
        tbl[15] = '{355, 1'b0, 1'b0, 12'h000, 19'd127};
        tbl[16] = '{449, 1'b1, 1'b1, 12'h000, 19'd127};
        tbl[17] = '{451, 1'b1, 1'b1, 12'h000, 19'd0};

        for (int i = 0; i < 128; i++) rnd_mem[i] = 16'($urandom);
        mode = 0;
        rstn = 1'b1;

        // Reset held for three clocks: outputs stay at reset values.
        repeat (3) step();
        check("rst_hs", 32'(hs), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);

        rstn = 1'b0;
        for (int i = 0; i < 18; i++) begin
            while (k < tbl[i].k) step();
            check("tbl_hs", 32'(hs), 32'(tbl[i].hs));
            check("tbl_vs", 32'(vs), 32'(tbl[i].vs));
            check("tbl_rgb", 32'(rgb), 32'(tbl[i].rgb));
            check("tbl_addr", 32'(mem_addr), 32'(tbl[i].addr));
        end
        check("first_hs_fall", 32'(first_hs_fall), 32'(HA + HFP + 3));
        while (k < 2 * FRAME + 10) step();

        // Single-clock reset in the middle of a frame.
        while ((k % FRAME) != 5 * HT + 10) step();
        rstn = 1'b1;
        step();
        check("mid_rst_hs", 32'(hs), 32'd1);
        check("mid_rst_vs", 32'(vs), 32'd1);
        check("mid_rst_rgb", 32'(rgb), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        rstn = 1'b0;
        while (k < HA + HFP + 3 + 5) step();
        check("mid_rst_hs_fall", 32'(first_hs_fall), 32'(HA + HFP + 3));
        while (k < FRAME + 20) step();

        // All-ones frame buffer: white exactly across each visible line.
        rstn = 1'b1;
        mode = 1;
        lines_ffff = 0;
        step();
        rstn = 1'b0;
        while (k < FRAME + 5) step();
        check("ffff_lines", 32'(lines_ffff), 32'(VA));

        // Random frame-buffer contents with a random-position reset.
        rstn = 1'b1;
        mode = 2;
        step();
        rstn = 1'b0;
        repeat ($urandom_range(50, 400)) step();
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        while (k < 2 * FRAME + 5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
